// File: rtl/seq_pkg.sv
// seq_pkg
//   Shared encodings for the multi-cycle sequencer and the blocks around it.
//   The instruction decoder and the datapath muxes import the same package.
//   Contents:
//     seq_state_t       FSM state encoding (also visible on the debug port)
//     OP_*              format=1 opcode values
//     WS_*              write_src mux encodings for the regfile write port
//     PC_*              pc_sel mux encodings for the PC input
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } seq_state_t;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_LOAD   = 4'b0001;
  localparam logic [3:0] OP_STORE  = 4'b0010;
  localparam logic [3:0] OP_JUMP   = 4'b0011;
  localparam logic [3:0] OP_BRANCH = 4'b0100;
  localparam logic [3:0] OP_EPAR   = 4'b0101;
  localparam logic [3:0] OP_CP     = 4'b0111;
  localparam logic [3:0] OP_SHIFT  = 4'b1010;
  localparam logic [3:0] OP_HALT   = 4'b1011;

  localparam logic [1:0] WS_MEM = 2'b00;
  localparam logic [1:0] WS_IMM = 2'b01;
  localparam logic [1:0] WS_RES = 2'b10;
  localparam logic [1:0] WS_ALU = 2'b11;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/seq_perf_counters.sv
// seq_perf_counters
//   Performance counters for the sequencer, built only with SEQ_PERF_EN.
//   Both counters clear on reset and wrap modulo 2^CNT_W.
// Ports:
//   clk          in   1      clock
//   reset        in   1      synchronous active-high reset
//   state        in   3      current sequencer state
//   pc_pulse     in   1      PC update strobe from the sequencer
//   cyc_count    out  CNT_W  cycles spent outside IDLE and HALT
//   instr_count  out  CNT_W  number of PC update pulses (retired instructions)
module seq_perf_counters
  import seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  seq_state_t       state,
  input  logic             pc_pulse,
  output logic [CNT_W-1:0] cyc_count,
  output logic [CNT_W-1:0] instr_count
);

  // Busy cycles and retired instructions; every instruction ends with exactly
  // one pc_en pulse except halt, which never updates the PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_count   <= '0;
      instr_count <= '0;
    end else begin
      if (state != IDLE && state != HALT) begin
        cyc_count <= cyc_count + CNT_W'(1);
      end
      if (pc_pulse) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM: FETCH, DECODE, EXEC, MEM, WB. Produces timed
//   strobes for the PC, IR, register file and the single shared memory port.
//   Optional feature macro: SEQ_PERF_EN adds cyc_count / instr_count.
// Parameters:
//   WAIT_MAX  cycles a memory request may wait for mem_ready before bus error
//   CNT_W     perf counter width (present only with SEQ_PERF_EN)
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 leave IDLE and fetch at the current PC
//   format, opcode, sign  IR fields (valid from DECODE onward)
//   br_cond               branch condition from the ALU, sampled in EXEC
//   mem_ready             memory completes the current request this cycle
//   mem_req, mem_we       memory request / write enable
//   mem_data              address mux select: 1 data access, 0 instruction fetch
//   ir_load               capture fetched word into IR
//   pc_en, pc_sel         PC update strobe and source select
//   reg_write, write_src  regfile write strobe and write data select
//   cpin, cpout           coprocessor transfer strobes
//   halted, bus_err       sticky status, cleared only by reset
//   state                 current FSM state (debug)
//   cyc_count, instr_count  perf counters (SEQ_PERF_EN only)
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int WAIT_MAX = 255
`ifdef SEQ_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             format,
  input  logic [3:0]       opcode,
  input  logic             sign,
  input  logic             br_cond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_data,
  output logic             ir_load,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             reg_write,
  output logic [1:0]       write_src,
  output logic             cpin,
  output logic             cpout,
  output logic             halted,
  output logic             bus_err,
  output logic [2:0]       state
`ifdef SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_count,
  output logic [CNT_W-1:0] instr_count
`endif
);

  // The wait counter only has to reach WAIT_MAX-1: the cycle that would make
  // it WAIT_MAX is the one that raises the bus error instead.
  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  seq_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [1:0]        write_src_q, write_src_d;
  logic              store_q, store_d;
  logic              bus_err_q, bus_err_d;
  logic              wait_expired;

  assign wait_expired = (wait_cnt_q == WAIT_W'(WAIT_MAX - 1));

  assign state     = state_q;
  assign write_src = write_src_q;
  assign bus_err   = bus_err_q;
  assign halted    = (state_q == HALT);

  // Next-state and strobe decode. Strobes are combinational from the current
  // state so a strobe always lines up with the cycle its state occupies;
  // ir_load and the MEM completion are qualified by mem_ready in that cycle.
  always_comb begin
    state_d     = state_q;
    write_src_d = write_src_q;
    store_d     = store_q;
    bus_err_d   = bus_err_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_data    = 1'b0;
    ir_load     = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = PC_NEXT;
    reg_write   = 1'b0;
    cpin        = 1'b0;
    cpout       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end else if (wait_expired) begin
          bus_err_d = 1'b1;
          state_d   = HALT;
        end
      end

      DECODE: begin
        state_d = EXEC;
      end

      // write_src is only reloaded for instructions that will write the
      // regfile, so it stays put for control-flow, store and halt.
      EXEC: begin
        if (!format) begin
          write_src_d = WS_IMM;
          state_d     = WB;
        end else begin
          case (opcode)
            OP_ADD, OP_SHIFT: begin
              write_src_d = WS_ALU;
              state_d     = WB;
            end
            OP_LOAD: begin
              write_src_d = WS_MEM;
              store_d     = 1'b0;
              state_d     = MEM;
            end
            OP_EPAR: begin
              write_src_d = WS_ALU;
              store_d     = 1'b0;
              state_d     = MEM;
            end
            OP_STORE: begin
              store_d = 1'b1;
              state_d = MEM;
            end
            OP_JUMP: begin
              pc_en   = 1'b1;
              pc_sel  = PC_JUMP;
              state_d = FETCH;
            end
            OP_BRANCH: begin
              pc_en   = 1'b1;
              pc_sel  = br_cond ? PC_BRANCH : PC_NEXT;
              state_d = FETCH;
            end
            OP_CP: begin
              cpout   = sign;
              cpin    = ~sign;
              pc_en   = 1'b1;
              state_d = FETCH;
            end
            OP_HALT: begin
              state_d = HALT;
            end
            default: begin
              write_src_d = WS_IMM;
              state_d     = WB;
            end
          endcase
        end
      end

      MEM: begin
        mem_req  = 1'b1;
        mem_data = 1'b1;
        mem_we   = store_q;
        if (mem_ready) begin
          if (store_q) begin
            pc_en   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (wait_expired) begin
          bus_err_d = 1'b1;
          state_d   = HALT;
        end
      end

      WB: begin
        reg_write = 1'b1;
        pc_en     = 1'b1;
        state_d   = FETCH;
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and context registers. The wait counter restarts whenever the
  // state changes, which covers every entry into FETCH or MEM, and only
  // advances while a request is outstanding without mem_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      write_src_q <= WS_IMM;
      store_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      write_src_q <= write_src_d;
      store_q     <= store_d;
      bus_err_q   <= bus_err_d;
      if (state_d != state_q) begin
        wait_cnt_q <= '0;
      end else if (mem_req && !mem_ready) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
    end
  end

`ifdef SEQ_PERF_EN
  seq_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk        (clk),
    .reset      (reset),
    .state      (state_q),
    .pc_pulse   (pc_en),
    .cyc_count  (cyc_count),
    .instr_count(instr_count)
  );
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer
//   Directed bench for multicycle_sequencer built with WAIT_MAX=4.
//   Perf counter checks are included when SEQ_PERF_EN is defined.
module tb_multicycle_sequencer;
  import seq_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        format;
  logic [3:0]  opcode;
  logic        sign;
  logic        br_cond;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_data;
  logic        ir_load;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        reg_write;
  logic [1:0]  write_src;
  logic        cpin;
  logic        cpout;
  logic        halted;
  logic        bus_err;
  logic [2:0]  state;
`ifdef SEQ_PERF_EN
  logic [31:0] cyc_count;
  logic [31:0] instr_count;
`endif

  int checks = 0;
  int errors = 0;

  // Every DUT output in one vector so each step compares the whole picture.
  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       data;
    logic       irl;
    logic       pce;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] ws;
    logic       ci;
    logic       co;
    logic       hlt;
    logic       berr;
  } obs_t;

  obs_t observed;
  assign observed = {state, mem_req, mem_we, mem_data, ir_load, pc_en, pc_sel,
                     reg_write, write_src, cpin, cpout, halted, bus_err};

  multicycle_sequencer #(
    .WAIT_MAX(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .format     (format),
    .opcode     (opcode),
    .sign       (sign),
    .br_cond    (br_cond),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_data   (mem_data),
    .ir_load    (ir_load),
    .pc_en      (pc_en),
    .pc_sel     (pc_sel),
    .reg_write  (reg_write),
    .write_src  (write_src),
    .cpin       (cpin),
    .cpout      (cpout),
    .halted     (halted),
    .bus_err    (bus_err),
    .state      (state)
`ifdef SEQ_PERF_EN
    ,
    .cyc_count  (cyc_count),
    .instr_count(instr_count)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if the sequence stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic st, input logic fmt, input logic [3:0] op,
                               input logic sg, input logic bc, input logic rdy);
    start     = st;
    format    = fmt;
    opcode    = op;
    sign      = sg;
    br_cond   = bc;
    mem_ready = rdy;
    #1;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // ctl = {mem_req, mem_we, mem_data, ir_load, pc_en}
  // misc = {cpin, cpout, halted, bus_err}
  task automatic checkOutput(input string tag, input logic [2:0] st, input logic [4:0] ctl,
                             input logic [1:0] pcs, input logic rw, input logic [1:0] ws,
                             input logic [3:0] misc);
    obs_t expected;
    expected = {st, ctl, pcs, rw, ws, misc};
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %05h expected %05h", tag, observed, expected);
    end
  endtask

  task automatic checkCount(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Called when the next edge enters FETCH; walks FETCH (ready at once) and
  // DECODE, and returns positioned in the EXEC cycle.
  task automatic runToExec(input string tag, input logic fmt, input logic [3:0] op,
                           input logic sg, input logic bc, input logic [1:0] ws);
    nextCycle;
    applyStimulus(1'b0, fmt, op, sg, bc, 1'b1);
    checkOutput({tag, "_fetch"}, FETCH, 5'b10010, 2'b00, 1'b0, ws, 4'b0000);
    nextCycle;
    applyStimulus(1'b0, fmt, op, sg, bc, 1'b0);
    checkOutput({tag, "_decode"}, DECODE, 5'b00000, 2'b00, 1'b0, ws, 4'b0000);
    nextCycle;
  endtask

  initial begin
    $display("[TB] multicycle_sequencer directed run");
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    nextCycle;
    nextCycle;
    checkOutput("reset_state", IDLE, 5'b00000, 2'b00, 1'b0, 2'b01, 4'b0000);
    reset = 1'b0;

    // add with immediate mem_ready; mem_ready in IDLE must be ignored
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    checkOutput("add_idle", IDLE, 5'b00000, 2'b00, 1'b0, 2'b01, 4'b0000);
    nextCycle;
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    checkOutput("add_fetch", FETCH, 5'b10010, 2'b00, 1'b0, 2'b01, 4'b0000);
    nextCycle;
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("add_decode", DECODE, 5'b00000, 2'b00, 1'b0, 2'b01, 4'b0000);
    nextCycle;
    checkOutput("add_exec", EXEC, 5'b00000, 2'b00, 1'b0, 2'b01, 4'b0000);
    nextCycle;
    checkOutput("add_wb", WB, 5'b00001, 2'b00, 1'b1, 2'b11, 4'b0000);

    // load with three wait cycles: mem_req held for four MEM cycles
    runToExec("load", 1'b1, 4'b0001, 1'b0, 1'b0, 2'b11);
    checkOutput("load_exec", EXEC, 5'b00000, 2'b00, 1'b0, 2'b11, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      nextCycle;
      checkOutput("load_mem_wait", MEM, 5'b10100, 2'b00, 1'b0, 2'b00, 4'b0000);
    end
    nextCycle;
    applyStimulus(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
    checkOutput("load_mem_ready", MEM, 5'b10100, 2'b00, 1'b0, 2'b00, 4'b0000);
    nextCycle;
    applyStimulus(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    checkOutput("load_wb", WB, 5'b00001, 2'b00, 1'b1, 2'b00, 4'b0000);

    // control flow: PC updated in EXEC, no regfile write, back to FETCH
    runToExec("br0", 1'b1, 4'b0100, 1'b0, 1'b0, 2'b00);
    checkOutput("br0_exec", EXEC, 5'b00001, 2'b00, 1'b0, 2'b00, 4'b0000);
    runToExec("br1", 1'b1, 4'b0100, 1'b0, 1'b1, 2'b00);
    checkOutput("br1_exec", EXEC, 5'b00001, 2'b01, 1'b0, 2'b00, 4'b0000);
    runToExec("jump", 1'b1, 4'b0011, 1'b0, 1'b0, 2'b00);
    checkOutput("jump_exec", EXEC, 5'b00001, 2'b10, 1'b0, 2'b00, 4'b0000);
    runToExec("cpout", 1'b1, 4'b0111, 1'b1, 1'b0, 2'b00);
    checkOutput("cpout_exec", EXEC, 5'b00001, 2'b00, 1'b0, 2'b00, 4'b0100);
    runToExec("cpin", 1'b1, 4'b0111, 1'b0, 1'b0, 2'b00);
    checkOutput("cpin_exec", EXEC, 5'b00001, 2'b00, 1'b0, 2'b00, 4'b1000);

    // store: write request with PC update in the completing MEM cycle
    runToExec("store", 1'b1, 4'b0010, 1'b0, 1'b0, 2'b00);
    checkOutput("store_exec", EXEC, 5'b00000, 2'b00, 1'b0, 2'b00, 4'b0000);
    nextCycle;
    applyStimulus(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1);
    checkOutput("store_mem", MEM, 5'b11101, 2'b00, 1'b0, 2'b00, 4'b0000);

    // write_src selection: undefined opcode, shift, immediate form
    runToExec("undef", 1'b1, 4'b1111, 1'b0, 1'b0, 2'b00);
    nextCycle;
    checkOutput("undef_wb", WB, 5'b00001, 2'b00, 1'b1, 2'b01, 4'b0000);
    runToExec("shift", 1'b1, 4'b1010, 1'b0, 1'b0, 2'b01);
    nextCycle;
    checkOutput("shift_wb", WB, 5'b00001, 2'b00, 1'b1, 2'b11, 4'b0000);
    runToExec("imm", 1'b0, 4'b0011, 1'b0, 1'b0, 2'b11);
    checkOutput("imm_exec", EXEC, 5'b00000, 2'b00, 1'b0, 2'b11, 4'b0000);
    nextCycle;
    checkOutput("imm_wb", WB, 5'b00001, 2'b00, 1'b1, 2'b01, 4'b0000);

    // halt: no PC update, sticky, start ignored, reset clears
    runToExec("halt", 1'b1, 4'b1011, 1'b0, 1'b0, 2'b01);
    checkOutput("halt_exec", EXEC, 5'b00000, 2'b00, 1'b0, 2'b01, 4'b0000);
    nextCycle;
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    checkOutput("halt_state", HALT, 5'b00000, 2'b00, 1'b0, 2'b01, 4'b0010);
    nextCycle;
    checkOutput("halt_start_ignored", HALT, 5'b00000, 2'b00, 1'b0, 2'b01, 4'b0010);
    reset = 1'b1;
    nextCycle;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("halt_reset", IDLE, 5'b00000, 2'b00, 1'b0, 2'b01, 4'b0000);

    // memory never answers: four wait cycles then bus error and HALT
    applyStimulus(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    runToExec("berr", 1'b1, 4'b0001, 1'b0, 1'b0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      nextCycle;
      checkOutput("berr_mem_wait", MEM, 5'b10100, 2'b00, 1'b0, 2'b00, 4'b0000);
    end
    nextCycle;
    checkOutput("berr_halt", HALT, 5'b00000, 2'b00, 1'b0, 2'b00, 4'b0011);
    reset = 1'b1;
    nextCycle;
    reset = 1'b0;
    checkOutput("berr_reset", IDLE, 5'b00000, 2'b00, 1'b0, 2'b01, 4'b0000);

    // reset during an outstanding store request drops mem_req next cycle
    applyStimulus(1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    runToExec("rstmem", 1'b1, 4'b0010, 1'b0, 1'b0, 2'b01);
    nextCycle;
    checkOutput("rstmem_mem", MEM, 5'b11100, 2'b00, 1'b0, 2'b01, 4'b0000);
    reset = 1'b1;
    nextCycle;
    checkOutput("rstmem_idle", IDLE, 5'b00000, 2'b00, 1'b0, 2'b01, 4'b0000);
    reset = 1'b0;

`ifdef SEQ_PERF_EN
    // three ALU ops, each fetch waiting one cycle: 5 busy cycles per op
    reset = 1'b1;
    nextCycle;
    reset = 1'b0;
    checkCount("perf_cyc_reset", cyc_count, 32'd0);
    checkCount("perf_instr_reset", instr_count, 32'd0);
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      nextCycle;
      applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle;
      applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
      nextCycle;
      applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle;
      nextCycle;
    end
    nextCycle;
    checkOutput("perf_state", FETCH, 5'b10000, 2'b00, 1'b0, 2'b11, 4'b0000);
    checkCount("perf_cyc", cyc_count, 32'd15);
    checkCount("perf_instr", instr_count, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
